// File: rtl/alu_pkg.sv
// Shared constants for the ALU command sequencer: widths, ALU control codes
// and the sequencer state encoding.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int NREGS  = 4;
    localparam int REG_AW = 2;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] INC = 3'b001;
    localparam logic [2:0] SUB = 3'b010;
    localparam logic [2:0] XOR = 3'b011;
    localparam logic [2:0] OR  = 3'b100;
    localparam logic [2:0] AND = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } seq_state_t;

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two combinational read ports, one clocked write port,
// every entry cleared by reset.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = regs[raddr1];
    assign rdata2 = regs[raddr2];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command-side driver for the 8-bit ALU: accepts load/ALU commands, drives the
// ALU operands from the register file, writes the result back and returns it.
module alu_op_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_ld,
    input  logic [2:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zero
);

    seq_state_t        state;
    logic [REG_AW-1:0] rd_q;
    logic              accept;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    assign accept = (state == IDLE) && cmd_valid && cmd_ready;

    alu_regfile u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .raddr1 (cmd_rs1),
        .raddr2 (cmd_rs2),
        .rdata1 (rf_rdata1),
        .rdata2 (rf_rdata2)
    );

    // Loads write on the accepting edge; ALU results write at the end of EXEC.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = alu_y;
        if (accept && cmd_ld) begin
            rf_we    = 1'b1;
            rf_waddr = cmd_rd;
            rf_wdata = cmd_imm;
        end else if (state == EXEC) begin
            rf_we    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_ctrl  <= 3'b000;
            rd_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        if (cmd_ld) begin
                            rsp_data  <= cmd_imm;
                            rsp_zero  <= (cmd_imm == '0);
                            rsp_valid <= 1'b1;
                            state     <= RESP;
                        end else begin
                            alu_a    <= rf_rdata1;
                            alu_b    <= rf_rdata2;
                            alu_ctrl <= cmd_op;
                            rd_q     <= cmd_rd;
                            state    <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rsp_data  <= alu_y;
                    rsp_zero  <= (alu_y == '0);
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: an in-bench ALU, a transaction-level reference
// model checked every cycle, and directed commands with literal expectations.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_ld = 1'b0;
    logic [2:0]        cmd_op = 3'b000;
    logic [REG_AW-1:0] cmd_rd = '0;
    logic [REG_AW-1:0] cmd_rs1 = '0;
    logic [REG_AW-1:0] cmd_rs2 = '0;
    logic [DATA_W-1:0] cmd_imm = '0;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_ctrl;
    logic [DATA_W-1:0] alu_y;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_zero;

    int compares = 0;
    int fails    = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_ld    (cmd_ld),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .cmd_imm   (cmd_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_y     (alu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_zero  (rsp_zero)
    );

    // The ALU the sequencer normally sits in front of.
    always_comb begin
        alu_y = '0;
        case (alu_ctrl)
            ADD:     alu_y = alu_a + alu_b;
            INC:     alu_y = alu_a + 8'd1;
            SUB:     alu_y = alu_a - alu_b;
            XOR:     alu_y = alu_a ^ alu_b;
            OR:      alu_y = alu_a | alu_b;
            AND:     alu_y = alu_a & alu_b;
            default: alu_y = '0;
        endcase
    end

    function automatic logic [7:0] aluRef(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int r;
        case (op)
            3'd0:    r = (int'(a) + int'(b)) % 256;
            3'd1:    r = (int'(a) + 1) % 256;
            3'd2:    r = (int'(a) - int'(b) + 256) % 256;
            3'd3:    r = int'(a ^ b);
            3'd4:    r = int'(a | b);
            3'd5:    r = int'(a & b);
            default: r = 0;
        endcase
        return 8'(r);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compares++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: registers, last ALU operands and the pending response.
    typedef struct {
        logic [7:0] data;
        logic       zero;
    } rsp_t;

    rsp_t       expQ[$];
    logic [7:0] mRegs [4];
    logic [7:0] mA;
    logic [7:0] mB;
    logic [2:0] mCtrl;
    bit         mBusy;
    int         mWait;

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] res;
        if (!rst_n) begin
            foreach (mRegs[i]) mRegs[i] = 8'h00;
            mA = 8'h00;
            mB = 8'h00;
            mCtrl = 3'b000;
            expQ.delete();
            mBusy = 1'b0;
            mWait = 0;
        end else if (mBusy) begin
            if (mWait > 0) begin
                mWait--;
            end else if (rsp_ready) begin
                expQ.delete(0);
                mBusy = 1'b0;
            end
        end else if (cmd_valid) begin
            if (cmd_ld) begin
                res = cmd_imm;
                mWait = 0;
            end else begin
                mA = mRegs[cmd_rs1];
                mB = mRegs[cmd_rs2];
                mCtrl = cmd_op;
                res = aluRef(cmd_op, mA, mB);
                mWait = 1;
            end
            mRegs[cmd_rd] = res;
            expQ.push_back('{res, res == 8'h00});
            mBusy = 1'b1;
        end
    end

    // Every cycle out of reset, compare the DUT against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("cmd_ready", 32'(cmd_ready), 32'(!mBusy));
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(mBusy && mWait == 0));
            checkOutput("alu_a", 32'(alu_a), 32'(mA));
            checkOutput("alu_b", 32'(alu_b), 32'(mB));
            checkOutput("alu_ctrl", 32'(alu_ctrl), 32'(mCtrl));
            if (mBusy && mWait == 0 && expQ.size() > 0) begin
                checkOutput("rsp_data", 32'(rsp_data), 32'(expQ[0].data));
                checkOutput("rsp_zero", 32'(rsp_zero), 32'(expQ[0].zero));
            end
        end
    end

    // Present one command for exactly one clock edge; returns just after that edge.
    task automatic applyStimulus(input logic ld, input logic [2:0] op, input int rd,
                                 input int rs1, input int rs2, input logic [7:0] imm);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_ld    = ld;
        cmd_op    = op;
        cmd_rd    = REG_AW'(rd);
        cmd_rs1   = REG_AW'(rs1);
        cmd_rs2   = REG_AW'(rs2);
        cmd_imm   = imm;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitResponse(input string name, input logic [7:0] expData, input logic expZero,
                                input int expLat, input bit consume);
        int lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, " data"}, 32'(rsp_data), 32'(expData));
        checkOutput({name, " zero"}, 32'(rsp_zero), 32'(expZero));
        if (consume) begin
            @(posedge clk);
            #1;
            checkOutput({name, " idle"}, 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] reset state");
        #12;
        checkOutput("rst cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst alu_a", 32'(alu_a), 32'd0);
        checkOutput("rst alu_b", 32'(alu_b), 32'd0);
        checkOutput("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
        checkOutput("rst rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst rsp_zero", 32'(rsp_zero), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            applyStimulus(1'b0, OR, r, r, r, 8'h00);
            waitResponse("rst reg", 8'h00, 1'b1, 2, 1'b1);
        end

        $display("[TB] loads and add");
        applyStimulus(1'b1, ADD, 0, 0, 0, 8'h7F);
        waitResponse("ld r0", 8'h7F, 1'b0, 1, 1'b1);
        applyStimulus(1'b1, ADD, 1, 0, 0, 8'h01);
        waitResponse("ld r1", 8'h01, 1'b0, 1, 1'b1);
        applyStimulus(1'b0, ADD, 2, 0, 1, 8'h00);
        waitResponse("add", 8'h80, 1'b0, 2, 1'b1);

        $display("[TB] increment wrap and subtract");
        applyStimulus(1'b1, ADD, 0, 0, 0, 8'hFF);
        waitResponse("ld ff", 8'hFF, 1'b0, 1, 1'b1);
        applyStimulus(1'b0, INC, 0, 0, 1, 8'h00);
        waitResponse("inc wrap", 8'h00, 1'b1, 2, 1'b1);
        applyStimulus(1'b0, SUB, 3, 1, 0, 8'h00);
        waitResponse("sub", 8'h01, 1'b0, 2, 1'b1);

        $display("[TB] xor self and unused codes");
        applyStimulus(1'b0, XOR, 1, 1, 1, 8'h00);
        waitResponse("xor self", 8'h00, 1'b1, 2, 1'b1);
        applyStimulus(1'b0, 3'b110, 2, 2, 3, 8'h00);
        waitResponse("ctrl 110", 8'h00, 1'b1, 2, 1'b1);
        applyStimulus(1'b0, 3'b111, 2, 3, 3, 8'h00);
        waitResponse("ctrl 111", 8'h00, 1'b1, 2, 1'b1);

        $display("[TB] backpressure");
        applyStimulus(1'b1, ADD, 2, 0, 0, 8'h5A);
        waitResponse("ld 5a", 8'h5A, 1'b0, 1, 1'b1);
        rsp_ready = 1'b0;
        applyStimulus(1'b0, ADD, 3, 2, 2, 8'h00);
        waitResponse("bp add", 8'hB4, 1'b0, 2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_ld    = 1'b1;
            cmd_rd    = 2'd2;
            cmd_imm   = 8'hAA;
            @(posedge clk);
            #1;
            checkOutput("bp hold valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp hold data", 32'(rsp_data), 32'hB4);
            checkOutput("bp cmd_ready", 32'(cmd_ready), 32'd0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release valid", 32'(rsp_valid), 32'd0);
        checkOutput("bp release ready", 32'(cmd_ready), 32'd1);
        applyStimulus(1'b0, OR, 2, 2, 2, 8'h00);
        waitResponse("ignored ld", 8'h5A, 1'b0, 2, 1'b1);
        applyStimulus(1'b0, AND, 0, 2, 3, 8'h00);
        waitResponse("and", 8'h10, 1'b0, 2, 1'b1);

        $display("[TB] reset during exec");
        applyStimulus(1'b0, ADD, 1, 2, 3, 8'h00);
        rst_n = 1'b0;
        #2;
        checkOutput("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("midrst held valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst alu_a", 32'(alu_a), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b0, OR, 1, 1, 1, 8'h00);
        waitResponse("midrst rd", 8'h00, 1'b1, 2, 1'b1);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
